// File: rtl/scan_loader.sv
// Purpose : scan-chain frame deserializer; turns {marker, addr, data} frames into SRAM writes during INIT.
// Latency : SC_CLK rise -> sr update 3 CLK edges; SC_EN fall -> o_wr_en 3 CLK edges.
// Backpr. : o_wr_en/addr/data held until i_wr_ready; a frame committed while a write is pending is dropped (o_frame_err).
//
// Ports   : CLK, RESETn (sync, active-low); scanIn/SC_CLK/SC_EN scan pins (async, sampled as data);
//           scanOut chain continuation; o_wr_en/o_wr_addr/o_wr_data/i_wr_ready SRAM write port;
//           o_init_done sticky terminator flag; o_frame_err one-cycle drop pulse.
// Option  : SCAN_LOADER_FRAME_CHECK_EN adds a bit counter and drops frames whose length is not FRAME_LEN.
module scan_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              scanIn,
  input  logic              SC_CLK,
  input  logic              SC_EN,
  output logic              scanOut,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  input  logic              i_wr_ready,
  output logic              o_init_done,
  output logic              o_frame_err
);

  localparam int FRAME_LEN = DATA_W + ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_SHIFT = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Two-stage synchronizers; [1] is the synchronized value.
  logic [1:0] din_s, sck_s, en_s;
  logic       sck_h, en_h;
  logic       sck_rise, en_fall;

  logic [FRAME_LEN-1:0] sr, sr_nxt;
  logic                 marker, all_ones, frame_ok;
  logic                 do_latch, err_nxt;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      din_s <= '0;
      sck_s <= '0;
      en_s  <= '0;
      sck_h <= 1'b0;
      en_h  <= 1'b0;
    end else begin
      din_s <= {din_s[0], scanIn};
      sck_s <= {sck_s[0], SC_CLK};
      en_s  <= {en_s[0], SC_EN};
      sck_h <= sck_s[1];
      en_h  <= en_s[1];
    end
  end

  assign sck_rise = sck_s[1] & ~sck_h;
  assign en_fall  = ~en_s[1] & en_h;

  // The commit decision must see a shift landing in the same cycle, so it
  // looks at the next value of sr rather than the registered one.
  assign sr_nxt   = sck_rise ? {din_s[1], sr[FRAME_LEN-1:1]} : sr;
  assign marker   = sr_nxt[FRAME_LEN-1];
  assign all_ones = &sr_nxt[FRAME_LEN-2:0];

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      sr      <= '0;
      scanOut <= 1'b0;
    end else if (sck_rise) begin
      sr      <= sr_nxt;
      scanOut <= sr[0];
    end
  end

`ifdef SCAN_LOADER_FRAME_CHECK_EN
  localparam int CW = $clog2(FRAME_LEN + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_LEN + 1);

  logic [CW-1:0] cnt, cnt_nxt;

  // Saturating one past a full frame keeps over-long frames distinguishable.
  assign cnt_nxt  = (sck_rise && cnt != CNT_SAT) ? cnt + 1'b1 : cnt;
  assign frame_ok = (cnt_nxt == CNT_FULL);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      cnt <= '0;
    end else if (en_fall) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state <= ST_SHIFT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    do_latch    = 1'b0;
    err_nxt     = 1'b0;
    o_wr_en     = (state == ST_WRITE);
    o_init_done = (state == ST_DONE);

    if (state == ST_WRITE && i_wr_ready) begin
      state_nxt = ST_SHIFT;
    end

    // Commit priority: DONE ignores, marker 0 ignores, bad length drops,
    // terminator wins over a pending write, then overrun, then a new write.
    if (en_fall && state != ST_DONE && marker) begin
      if (!frame_ok) begin
        err_nxt = 1'b1;
      end else if (all_ones) begin
        state_nxt = ST_DONE;
      end else if (state == ST_WRITE) begin
        err_nxt = 1'b1;
      end else begin
        do_latch  = 1'b1;
        state_nxt = ST_WRITE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= err_nxt;
      if (do_latch) begin
        o_wr_addr <= sr_nxt[DATA_W+ADDR_W-1:DATA_W];
        o_wr_data <= sr_nxt[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_scan_loader.sv
module tb_scan_loader;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int FL = DW + AW + 1;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          scanIn = 1'b0;
  logic          SC_CLK = 1'b0;
  logic          SC_EN = 1'b1;
  logic          scanOut;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          i_wr_ready = 1'b1;
  logic          o_init_done;
  logic          o_frame_err;

  scan_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESETn(RESETn), .scanIn(scanIn), .SC_CLK(SC_CLK), .SC_EN(SC_EN),
    .scanOut(scanOut), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .i_wr_ready(i_wr_ready), .o_init_done(o_init_done), .o_frame_err(o_frame_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Observed side
  logic [AW+DW-1:0] wr_q[$];
  int err_cnt = 0;
  int en_cycles = 0;

  always @(posedge CLK) begin
    if (o_wr_en && i_wr_ready) wr_q.push_back({o_wr_addr, o_wr_data});
    if (o_frame_err) err_cnt++;
    if (o_wr_en) en_cycles++;
  end

  // Reference model: every bit shifted since reset, prefixed by FL zeros.
  bit hist[$];
  int nbits = 0;
  bit done_m = 0;
  int exp_err = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < FL; k++) hist.push_back(1'b0);
    nbits = 0;
    done_m = 0;
    exp_q.delete();
    wr_q.delete();
  endtask

  task automatic shift_bit(bit b);
    scanIn = b;
    SC_CLK = 1'b0;
    cyc(4);
    SC_CLK = 1'b1;
    cyc(4);
    hist.push_back(b);
    nbits++;
  endtask

  task automatic send_bits(logic [63:0] v, int n);
    for (int i = 0; i < n; i++) shift_bit(v[i]);
  endtask

  // Frame interpretation from the wire-order rules: last FL bits, oldest at LSB.
  task automatic commit(bit pending);
    logic [FL-1:0] f;
    bit short_frame;
    SC_CLK = 1'b0;
    cyc(4);
    SC_EN = 1'b0;
    cyc(4);
    SC_EN = 1'b1;
    cyc(4);
    for (int k = 0; k < FL; k++) f[k] = hist[hist.size() - FL + k];
`ifdef SCAN_LOADER_FRAME_CHECK_EN
    short_frame = (nbits != FL);
`else
    short_frame = 1'b0;
`endif
    nbits = 0;
    if (done_m || !f[FL-1]) begin
      // ignored
    end else if (short_frame) begin
      exp_err++;
    end else if (f[FL-2:0] == {(FL-1){1'b1}}) begin
      done_m = 1;
    end else if (pending) begin
      exp_err++;
    end else begin
      exp_q.push_back(f[FL-2:0]);
    end
  endtask

  task automatic verify(string tag);
    int n;
    cyc(10);
    check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_wr"}, 64'(wr_q[i]), 64'(exp_q[i]));
    check({tag, "_err"}, 64'(err_cnt), 64'(exp_err));
    check({tag, "_done"}, 64'(o_init_done), 64'(done_m));
    wr_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [63:0] frame(bit m, logic [AW-1:0] a, logic [DW-1:0] d);
    return 64'({m, a, d});
  endfunction

  initial begin
    int base;
    int stable;
    bit seen;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    // Reset state
    model_reset();
    RESETn = 1'b0;
    cyc(3);
    check("reset_outs", 64'({scanOut, o_wr_en, o_wr_addr, o_wr_data, o_init_done, o_frame_err}), 64'd0);
    RESETn = 1'b1;
    cyc(5);

    // Single write, exactly one o_wr_en cycle
    base = en_cycles;
    send_bits(frame(1'b1, 8'h21, 32'h03020100), FL);
    commit(1'b0);
    verify("single");
    check("single_encyc", 64'(en_cycles - base), 64'd1);

    // Marker zero
    send_bits(frame(1'b0, 8'h10, 32'hDEADBEEF), FL);
    commit(1'b0);
    verify("marker0");

    // Random frames against the model
    for (int t = 0; t < 8; t++) begin
      ra = 8'($urandom);
      rd = $urandom;
      send_bits(frame(($urandom_range(0, 3) != 0), ra, rd), FL);
      commit(1'b0);
      verify("rand");
    end
    check("scanout", 64'(scanOut), 64'(hist[hist.size() - FL - 1]));

    // Backpressure: request held stable, overrun frame dropped
    i_wr_ready = 1'b0;
    send_bits(frame(1'b1, 8'h22, 32'hFF060504), FL);
    commit(1'b1 == 1'b0);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (o_wr_en) seen = 1;
      else cyc(1);
    end
    check("bp_req_seen", 64'(seen), 64'd1);
    stable = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_wr_en && o_wr_addr == 8'h22 && o_wr_data == 32'hFF060504) stable++;
      cyc(1);
    end
    check("bp_stable", 64'(stable), 64'd6);
    send_bits(frame(1'b1, 8'h33, 32'h0BADF00D), FL);
    commit(1'b1);
    check("bp_nowr_yet", 64'(wr_q.size()), 64'd0);
    i_wr_ready = 1'b1;
    verify("bp");

    // Short frame (40 bits, last bit 1)
    send_bits(frame(1'b0, 8'hAA, 32'h12345678) | 64'h80_0000_0000, FL - 1);
    commit(1'b0);
    verify("short");

    // Terminator, then a later valid frame is ignored
    send_bits(64'h1FF_FFFF_FFFF, FL);
    commit(1'b0);
    verify("term");
    send_bits(frame(1'b1, 8'h05, 32'h55AA55AA), FL);
    commit(1'b0);
    verify("post_done");

    // Reset in the middle of a frame
    send_bits(frame(1'b1, 8'h77, 32'h77777777), 20);
    SC_CLK = 1'b0;
    cyc(4);
    RESETn = 1'b0;
    cyc(3);
    check("midreset_outs", 64'({scanOut, o_wr_en, o_wr_addr, o_wr_data, o_init_done, o_frame_err}), 64'd0);
    model_reset();
    RESETn = 1'b1;
    cyc(5);
    send_bits(frame(1'b1, 8'h00, 32'h00000001), FL);
    commit(1'b0);
    verify("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
